// File: rtl/seq_multdiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seq_multdiv_unit                                              |
// | Description: Iterative signed multiply (radix-2 Booth) / divide (restoring)|
// |              unit, one iteration per clock, start/ready handshake.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module seq_multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             ctrl_busy
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic               r_is_mult;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_div_zero;
  logic               r_div_ovf;
  logic               r_neg;

  // Booth accumulator: {hi[WIDTH:0], lo[WIDTH-1:0], q_-1}; hi carries one
  // guard bit so that subtracting the most-negative multiplicand cannot wrap.
  logic [2*WIDTH+1:0] r_acc;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;

  logic               w_start;
  logic               w_finish;
  logic [WIDTH:0]     w_booth_hi;
  logic [2*WIDTH+1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_product;
  logic               w_mul_ovf;
  logic [WIDTH:0]     w_r_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_quo_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_start  = (r_state != S_RUN) && (ctrl_MULT || ctrl_DIV);
  assign w_finish = (r_state == S_RUN) &&
                    ((r_cnt == c_LAST) || (!r_is_mult && r_div_zero));

  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_comb begin
    w_booth_hi = r_acc[2*WIDTH+1:WIDTH+1];
    case (r_acc[1:0])
      2'b01:   w_booth_hi = r_acc[2*WIDTH+1:WIDTH+1] + r_mcand;
      2'b10:   w_booth_hi = r_acc[2*WIDTH+1:WIDTH+1] - r_mcand;
      default: w_booth_hi = r_acc[2*WIDTH+1:WIDTH+1];
    endcase
  end

  assign w_acc_next = {w_booth_hi[WIDTH], w_booth_hi, r_acc[WIDTH:1]};
  assign w_product  = w_acc_next[2*WIDTH:1];
  assign w_mul_ovf  = !((&w_product[2*WIDTH-1:WIDTH-1]) ||
                        (~|w_product[2*WIDTH-1:WIDTH-1]));

  // Remainder stays below the divisor, so WIDTH bits hold it after each step.
  assign w_r_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge         = (w_r_shift >= {1'b0, r_divisor});
  assign w_diff       = w_r_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next   = w_ge ? w_diff : w_r_shift[WIDTH-1:0];
  assign w_quo_next   = {r_quo[WIDTH-2:0], w_ge};
  assign w_quo_signed = r_neg ? -w_quo_next : w_quo_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    data_resultRDY = 1'b0;
    ctrl_busy      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_RUN;
      S_RUN: begin
        ctrl_busy = 1'b1;
        if (w_finish) w_state_next = S_DONE;
      end
      S_DONE: begin
        data_resultRDY = 1'b1;
        w_state_next   = w_start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_is_mult      <= 1'b0;
      r_cnt          <= '0;
      r_div_zero     <= 1'b0;
      r_div_ovf      <= 1'b0;
      r_neg          <= 1'b0;
      r_acc          <= '0;
      r_mcand        <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_divisor      <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (w_start) begin
      r_is_mult  <= ctrl_MULT;
      r_cnt      <= '0;
      r_div_zero <= (data_operandB == '0);
      r_div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (data_operandB == {WIDTH{1'b1}});
      r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_acc      <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      r_mcand    <= {data_operandA[WIDTH-1], data_operandA};
      r_rem      <= '0;
      r_quo      <= w_abs_a;
      r_divisor  <= w_abs_b;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + c_ONE;
      if (r_is_mult) begin
        r_acc <= w_acc_next;
      end else begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
      if (w_finish) begin
        if (r_is_mult) begin
          data_result    <= w_product[WIDTH-1:0];
          data_exception <= w_mul_ovf;
        end else if (r_div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= w_quo_signed;
          data_exception <= r_div_ovf;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_multdiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_seq_multdiv_unit                                           |
// | Description: Directed self-checking bench for seq_multdiv_unit.            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_seq_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        ctrl_busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int rdy_seen;

  seq_multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_busy      (ctrl_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start now, let one edge sample it, then scramble the operands.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges after the start edge until RDY is seen (-1 on timeout); optionally
  // pulses ctrl_DIV while the operation is running.
  task automatic wait_rdy(input int inject, output int latency);
    latency = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        latency = i;
        break;
      end
      if (i == inject) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic d, input logic [31:0] exp_res,
                        input logic exp_exc, input int exp_lat, input int inject);
    int l;
    @(negedge clock);
    start_op(a, b, m, d);
    chk({tag, "_busy"}, {31'd0, ctrl_busy}, 32'd1);
    wait_rdy(inject, l);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_res"}, data_result, exp_res);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(posedge clock); #1;
    chk({tag, "_rdy_one"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, "_idle"}, {31'd0, ctrl_busy}, 32'd0);
    chk({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_res", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, ctrl_busy}, 32'd0);
    reset = 1'b1;

    run_op("mul_7xm3",    32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0, 32, 0);
    run_op("mul_ovf",     32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1, 32, 0);
    run_op("mul_m1xm1",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001, 1'b0, 32, 0);
    run_op("div_m17_5",   32'hFFFFFFEF, 32'd5,        1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 32, 0);
    run_op("div_100_m7",  32'd100,      32'hFFFFFFF9, 1'b0, 1'b1, 32'hFFFFFFF2, 1'b0, 32, 0);
    run_op("div_min_m1",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 32, 0);
    run_op("div_zero",    32'd5,        32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1, 1,  0);
    run_op("mul_ignore",  32'd1000,     32'd3,        1'b1, 1'b0, 32'h00000BB8, 1'b0, 32, 10);
    run_op("both_high",   32'd12,       32'd4,        1'b1, 1'b1, 32'h00000030, 1'b0, 32, 0);

    // Start accepted in the DONE cycle goes straight back to RUN.
    @(negedge clock);
    start_op(32'd2, 32'd3, 1'b1, 1'b0);
    wait_rdy(0, lat);
    chk("b2b_first_lat", lat, 32'd32);
    chk("b2b_first_res", data_result, 32'd6);
    start_op(32'hFFFFFFFA, 32'd9, 1'b1, 1'b0);
    chk("b2b_busy", {31'd0, ctrl_busy}, 32'd1);
    chk("b2b_hold_old", data_result, 32'd6);
    wait_rdy(0, lat);
    chk("b2b_second_lat", lat, 32'd32);
    chk("b2b_second_res", data_result, 32'hFFFFFFCA);

    // Reset during a multiply discards it; no RDY afterwards.
    @(negedge clock);
    start_op(32'd100, 32'd100, 1'b1, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_res", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("midrst_busy", {31'd0, ctrl_busy}, 32'd0);
    reset = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY || ctrl_busy) rdy_seen++;
    end
    chk("midrst_no_rdy", rdy_seen, 32'd0);

    run_op("mul_after_rst", 32'hFFFFFFEC, 32'd25, 1'b1, 1'b0, 32'hFFFFFE0C, 1'b0, 32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
